// File: rtl/gpio_bus_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a GPIO register block.
// slave = arbiter side, master = requester / register-block side.
interface gpio_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              gpio_we;
    logic [ADDR_W-1:0] gpio_addr;
    logic [DATA_W-1:0] gpio_data_in;
    logic [DATA_W-1:0] gpio_data_out;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, gpio_data_out,
        output gnt0, gnt1, done0, done1, rdata0, rdata1,
               gpio_we, gpio_addr, gpio_data_in, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, gpio_data_out,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1,
               gpio_we, gpio_addr, gpio_data_in, busy
    );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester arbiter in front of a GPIO register block: IDLE -> ACCESS -> RESP.
// Define GPIO_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
//
// Handshake: a requester raises reqN with we/addr/wdata and holds it until doneN.
// The request is sampled only in IDLE; gntN pulses in the ACCESS cycle and doneN
// pulses in the RESP cycle, with rdataN valid while doneN is high.
module gpio_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 pclk,
    input  logic                 preset,
    gpio_bus_arbiter_if.slave    bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_gnt;
    logic [1:0]        r_done;
    logic              r_gpio_we;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_any;
    logic              w_win;

    assign w_any = bus.req0 | bus.req1;

`ifdef GPIO_ARB_RR_EN
    // r_last is the index served most recently; reset to 1 so requester 0 wins first.
    logic r_last;
    assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    always_ff @(posedge pclk) begin
        if (preset)
            r_last <= 1'b1;
        else if (r_state == ST_IDLE && w_any)
            r_last <= w_win;
    end
`else
    assign w_win = ~bus.req0;
`endif

    // The address/data registers double as the latched copy and as the bus outputs,
    // so they are cleared on leaving ACCESS to keep the GPIO bus at 0 otherwise.
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= ST_IDLE;
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_gnt     <= 2'b00;
            r_done    <= 2'b00;
            r_gpio_we <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win     <= w_win;
                        r_we      <= w_win ? bus.we1 : bus.we0;
                        r_gpio_we <= w_win ? bus.we1 : bus.we0;
                        r_addr    <= w_win ? bus.addr1 : bus.addr0;
                        r_wdata   <= w_win ? bus.wdata1 : bus.wdata0;
                        r_gnt     <= w_win ? 2'b10 : 2'b01;
                        r_busy    <= 1'b1;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_gnt     <= 2'b00;
                    r_gpio_we <= 1'b0;
                    r_addr    <= '0;
                    r_wdata   <= '0;
                    r_done    <= r_win ? 2'b10 : 2'b01;
                    if (!r_we) begin
                        if (r_win)
                            r_rdata1 <= bus.gpio_data_out;
                        else
                            r_rdata0 <= bus.gpio_data_out;
                    end
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0         = r_gnt[0];
    assign bus.gnt1         = r_gnt[1];
    assign bus.done0        = r_done[0];
    assign bus.done1        = r_done[1];
    assign bus.rdata0       = r_rdata0;
    assign bus.rdata1       = r_rdata1;
    assign bus.gpio_we      = r_gpio_we;
    assign bus.gpio_addr    = r_addr;
    assign bus.gpio_data_in = r_wdata;
    assign bus.busy         = r_busy;
    assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Self-checking bench for gpio_bus_arbiter: directed scenarios plus random transfers
// checked against a transaction-level model of the arbitration and read-data rules.
module tb_gpio_bus_arbiter;
    logic       pclk = 1'b0;
    logic       preset;
    logic [1:0] dbg_state;
    int         errors = 0;
    int         checks = 0;

    // Model state: who was served last, and what each requester's rdata should hold.
    bit          m_last = 1'b1;
    logic [31:0] m_rdata [2];

    gpio_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    gpio_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   {bus.gnt1, bus.gnt0}, 0);
        chk({tag, "_done"},  {bus.done1, bus.done0}, 0);
        chk({tag, "_we"},    bus.gpio_we, 0);
        chk({tag, "_addr"},  bus.gpio_addr, 0);
        chk({tag, "_din"},   bus.gpio_data_in, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_rd0"},   bus.rdata0, 0);
        chk({tag, "_rd1"},   bus.rdata1, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    function automatic bit pick_winner(input bit r0, input bit r1);
`ifdef GPIO_ARB_RR_EN
        return (r0 && r1) ? !m_last : r1;
`else
        return !r0;
`endif
    endfunction

    // Entered and left just after a falling edge with the DUT in IDLE.
    task automatic do_xfer(input string tag, input bit r0, input bit r1,
                           input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] rd, input bit keep_req,
                           output bit won);
        bit          win;
        bit          xwe;
        logic [31:0] xa;
        logic [31:0] xd;
        bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
        bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_done"}, {bus.done1, bus.done0}, 0);
        win = pick_winner(r0, r1);
        won = win;
        @(posedge pclk); @(negedge pclk);
        if (!(r0 || r1)) begin
            chk({tag, "_stay_idle"}, {bus.busy, bus.gnt1, bus.gnt0}, 0);
            return;
        end
        m_last = win;
        xwe = win ? w1 : w0;
        xa  = win ? a1 : a0;
        xd  = win ? d1 : d0;
        // Disturb every request input mid-transfer; the transfer must not notice.
        if (!keep_req) begin
            bus.req0 = 1'($urandom_range(0, 1));
            bus.req1 = 1'($urandom_range(0, 1));
        end
        bus.we0 = ~w0; bus.we1 = ~w1;
        bus.addr0 = a0 ^ 32'h10; bus.addr1 = $urandom;
        bus.wdata0 = $urandom; bus.wdata1 = $urandom;
        bus.gpio_data_out = rd;
        #1;
        chk({tag, "_acc_gnt"},  {bus.gnt1, bus.gnt0}, win ? 2'b10 : 2'b01);
        chk({tag, "_acc_we"},   bus.gpio_we, xwe);
        chk({tag, "_acc_addr"}, bus.gpio_addr, xa);
        chk({tag, "_acc_din"},  bus.gpio_data_in, xd);
        chk({tag, "_acc_busy"}, bus.busy, 1);
        chk({tag, "_acc_done"}, {bus.done1, bus.done0}, 0);
        if (!xwe) m_rdata[win] = rd;
        @(posedge pclk); @(negedge pclk);
        chk({tag, "_rsp_done"}, {bus.done1, bus.done0}, win ? 2'b10 : 2'b01);
        chk({tag, "_rsp_gnt"},  {bus.gnt1, bus.gnt0}, 0);
        chk({tag, "_rsp_bus"},  {bus.gpio_we, bus.gpio_addr, bus.gpio_data_in}, 0);
        chk({tag, "_rsp_busy"}, bus.busy, 1);
        chk({tag, "_rsp_rd0"},  bus.rdata0, m_rdata[0]);
        chk({tag, "_rsp_rd1"},  bus.rdata1, m_rdata[1]);
        @(posedge pclk); @(negedge pclk);
    endtask

    initial begin
        bit won;
        bit r0, r1;
        bit exp_seq;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.gpio_data_out = '0;
        preset = 1'b1;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        chk_all_zero("reset");
        preset = 1'b0;

        // Write from requester 0, then a read so rdata0 is non-zero.
        do_xfer("wr0", 1, 0, 1, 0, 32'h04, 32'h0, 32'd45, 32'h0, 32'hdead, 0, won);
        do_xfer("rd0", 1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h0, 32'h77, 0, won);
        // Read from requester 1 leaves rdata0 alone.
        do_xfer("rd1", 0, 1, 0, 0, 32'h0, 32'h08, 32'h0, 32'h0, 32'd12, 0, won);
        do_xfer("wr1", 0, 1, 0, 1, 32'h0, 32'h0c, 32'h0, 32'h99, 32'h55, 0, won);
        do_xfer("none", 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, won);

        // Both held high: alternate under round-robin, requester 0 always otherwise.
        exp_seq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_xfer("held", 1, 1, 0, 0, 32'h40 + i, 32'h80 + i, 32'h0, 32'h0, $urandom, 1, won);
            chk("held_order", won, exp_seq);
`ifdef GPIO_ARB_RR_EN
            exp_seq = ~exp_seq;
`endif
        end

        // Reset in the middle of a write's ACCESS cycle.
        do_xfer("pre", 1, 0, 0, 0, 32'h30, 32'h0, 32'h0, 32'h0, 32'h1234, 0, won);
        bus.req0 = 1; bus.req1 = 0; bus.we0 = 1; bus.addr0 = 32'h44; bus.wdata0 = 32'h66;
        @(posedge pclk); @(negedge pclk);
        chk("rst_pre_gnt", bus.gnt0, 1);
        preset = 1'b1;
        @(posedge pclk); @(negedge pclk);
        preset = 1'b0;
        chk_all_zero("rst_mid");
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        do_xfer("post_rst", 1, 1, 0, 0, 32'h50, 32'h54, 32'h0, 32'h0, 32'hbeef, 0, won);
        chk("post_rst_win", won, 0);

        for (int i = 0; i < 24; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            do_xfer("rand", r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom, $urandom, 0, won);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
